// File: rtl/edge_bit_timer_if.sv
// Control/status bundle for edge_bit_timer.
// Master drives the frame configuration; slave (the timer) drives status.
interface edge_bit_timer_if #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
);

  logic                      enable;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [BIT_CNT_WIDTH-1:0]  frame_bits;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      sample_strobe;
  logic                      sample_last;
  logic                      bit_done;
  logic                      frame_done;
  logic                      cfg_err;

  modport master (
    output enable,
    output prescale,
    output frame_bits,
    input  edge_cnt,
    input  bit_cnt,
    input  sample_strobe,
    input  sample_last,
    input  bit_done,
    input  frame_done,
    input  cfg_err
  );

  modport slave (
    input  enable,
    input  prescale,
    input  frame_bits,
    output edge_cnt,
    output bit_cnt,
    output sample_strobe,
    output sample_last,
    output bit_done,
    output frame_done,
    output cfg_err
  );

endinterface

// File: rtl/edge_bit_timer.sv
// Oversampled bit/frame timer: edge and bit counters, sample strobes.
// Define MAJORITY_VOTE_EN for three strobes per bit around the centre.
module edge_bit_timer #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4,
  parameter int MIN_PRESCALE   = 4
) (
  input  logic            CLK,
  input  logic            RST,
  edge_bit_timer_if.slave bus
);

  localparam logic [PRESCALE_WIDTH-1:0] PsOne =
    PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PsMin =
    PRESCALE_WIDTH'(MIN_PRESCALE);
  localparam logic [BIT_CNT_WIDTH-1:0]  BcOne =
    BIT_CNT_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  BcMin =
    BIT_CNT_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [PRESCALE_WIDTH-1:0] ps_q, ps_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_q, bit_d;
  logic [BIT_CNT_WIDTH-1:0]  fb_q, fb_d;

  logic                      cfg_ok;
  logic                      run;
  logic                      last_edge;
  logic                      last_bit;
  logic                      bit_done;
  logic                      frame_done;
  logic                      strobe;
  logic                      strobe_last;
  logic [PRESCALE_WIDTH-1:0] centre;

  assign cfg_ok = (bus.prescale >= PsMin) &&
                  (bus.frame_bits >= BcMin);

  // enable low suppresses every pulse in the aborting cycle
  assign run        = (state_q == COUNT) && bus.enable;
  assign last_edge  = edge_q == (ps_q - PsOne);
  assign last_bit   = bit_q == (fb_q - BcOne);
  assign bit_done   = run && last_edge;
  assign frame_done = bit_done && last_bit;
  assign centre     = ps_q >> 1;

`ifdef MAJORITY_VOTE_EN
  assign strobe = run &&
                  ((edge_q == (centre - PsOne)) ||
                   (edge_q == centre) ||
                   (edge_q == (centre + PsOne)));
  assign strobe_last = run && (edge_q == (centre + PsOne));
`else
  assign strobe      = run && (edge_q == centre);
  assign strobe_last = strobe;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      ps_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      ps_q    <= ps_d;
      fb_q    <= fb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    ps_d    = ps_q;
    fb_d    = fb_q;
    unique case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (bus.enable && cfg_ok) begin
          state_d = COUNT;
          ps_d    = bus.prescale;
          fb_d    = bus.frame_bits;
        end
      end
      COUNT: begin
        if (!bus.enable) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (frame_done) begin
          state_d = DONE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (last_edge) begin
          edge_d = '0;
          bit_d  = bit_q + BcOne;
        end else begin
          edge_d = edge_q + PsOne;
        end
      end
      DONE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!bus.enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign bus.edge_cnt      = edge_q;
  assign bus.bit_cnt       = bit_q;
  assign bus.sample_strobe = strobe;
  assign bus.sample_last   = strobe_last;
  assign bus.bit_done      = bit_done;
  assign bus.frame_done    = frame_done;
  // held low while reset is asserted, whatever the inputs say
  assign bus.cfg_err       = RST && (state_q == IDLE) &&
                             bus.enable && !cfg_ok;

endmodule

// File: tb/tb_edge_bit_timer.sv
// Directed bench for edge_bit_timer: config table plus abort/reset cases.
// Honours MAJORITY_VOTE_EN when building the expected strobe pattern.
`timescale 1ns/1ps
module tb_edge_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  edge_bit_timer_if #(
    .PRESCALE_WIDTH(PW),
    .BIT_CNT_WIDTH (BW)
  ) bus ();

  edge_bit_timer #(
    .PRESCALE_WIDTH(PW),
    .BIT_CNT_WIDTH (BW),
    .MIN_PRESCALE  (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    int p;
    int fb;
    bit legal;
    int c;
    int len;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input int act,
                       input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int outsum();
    return int'(bus.edge_cnt) + int'(bus.bit_cnt) +
           int'(bus.sample_strobe) + int'(bus.sample_last) +
           int'(bus.bit_done) + int'(bus.frame_done);
  endfunction

  // Called right after the enabling inputs are driven; walks the frame.
  task automatic run_frame(input int p, input int c, input int fb,
                           input int chg_bit, input int chg_val,
                           output int len, output int nbits,
                           output int errs);
    int  e_exp;
    int  b_exp;
    bit  s_exp;
    bit  l_exp;
    len   = -1;
    nbits = 0;
    errs  = 0;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge CLK);
      e_exp = (n - 1) % p;
      b_exp = (n - 1) / p;
`ifdef MAJORITY_VOTE_EN
      s_exp = (e_exp >= c - 1) && (e_exp <= c + 1);
      l_exp = (e_exp == c + 1);
`else
      s_exp = (e_exp == c);
      l_exp = s_exp;
`endif
      if (bus.edge_cnt !== PW'(e_exp) ||
          bus.bit_cnt !== BW'(b_exp) ||
          bus.sample_strobe !== s_exp ||
          bus.sample_last !== l_exp ||
          bus.bit_done !== (e_exp == p - 1) ||
          bus.frame_done !== (n == fb * p) ||
          bus.cfg_err !== 1'b0)
        errs++;
      if (bus.bit_done) nbits++;
      if (chg_bit >= 0 && b_exp == chg_bit)
        bus.prescale = PW'(chg_val);
      if (bus.frame_done) begin
        len = n;
        break;
      end
    end
  endtask

  task automatic start(input int p, input int fb);
    bus.enable = 1'b0;
    repeat (2) @(negedge CLK);
    bus.prescale   = PW'(p);
    bus.frame_bits = BW'(fb);
    bus.enable     = 1'b1;
  endtask

  task automatic wait_pos(input int b, input int e,
                          output bit found);
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (bus.bit_cnt == BW'(b) && bus.edge_cnt == PW'(e)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int len, nb, errs, acc;
    bit found;

    vecs[0] = '{8,  10, 1'b1, 4,  80};
    vecs[1] = '{4,  2,  1'b1, 2,  8};
    vecs[2] = '{5,  3,  1'b1, 2,  15};
    vecs[3] = '{63, 2,  1'b1, 31, 126};
    vecs[4] = '{3,  10, 1'b0, 0,  0};
    vecs[5] = '{8,  1,  1'b0, 0,  0};
    vecs[6] = '{16, 15, 1'b1, 8,  240};
    vecs[7] = '{0,  0,  1'b0, 0,  0};

    // reset state, with an illegal config already enabled
    bus.enable     = 1'b1;
    bus.prescale   = PW'(3);
    bus.frame_bits = BW'(10);
    #22;
    check("reset_outputs", outsum(), 0);
    check("reset_cfg_err", int'(bus.cfg_err), 0);
    @(negedge CLK);
    bus.enable = 1'b0;
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].p, vecs[i].fb);
      #1;
      check($sformatf("v%0d_cfg_err", i), int'(bus.cfg_err),
            vecs[i].legal ? 0 : 1);
      if (vecs[i].legal) begin
        run_frame(vecs[i].p, vecs[i].c, vecs[i].fb, -1, 0,
                  len, nb, errs);
        check($sformatf("v%0d_len", i), len, vecs[i].len);
        check($sformatf("v%0d_bits", i), nb, vecs[i].fb);
        check($sformatf("v%0d_seq", i), errs, 0);
        acc = 0;
        repeat (5) begin
          @(negedge CLK);
          acc += outsum();
        end
        check($sformatf("v%0d_done_hold", i), acc, 0);
      end else begin
        acc = 0;
        repeat (5) begin
          @(negedge CLK);
          acc += outsum() + (bus.cfg_err ? 0 : 1);
        end
        check($sformatf("v%0d_illegal_hold", i), acc, 0);
      end
    end

    // illegal config becomes legal while enabled
    start(3, 10);
    repeat (3) @(negedge CLK);
    check("cfg_err_set", int'(bus.cfg_err), 1);
    bus.prescale = PW'(16);
    #1;
    check("cfg_err_clear", int'(bus.cfg_err), 0);
    @(negedge CLK);
    @(negedge CLK);
    check("count_next_edge", int'(bus.edge_cnt), 1);

    // prescale change mid-frame is ignored
    start(8, 10);
    run_frame(8, 4, 10, 2, 16, len, nb, errs);
    check("latched_len", len, 80);
    check("latched_seq", errs, 0);

    // abort at bit 5 edge 3, then restart from bit 0
    start(8, 10);
    wait_pos(5, 3, found);
    check("abort_found", int'(found), 1);
    bus.enable = 1'b0;
    #1;
    check("abort_gate", outsum() - 5 - 3, 0);
    acc = 0;
    repeat (3) begin
      @(negedge CLK);
      acc += outsum();
    end
    check("abort_idle", acc, 0);
    bus.enable = 1'b1;
    run_frame(8, 4, 10, -1, 0, len, nb, errs);
    check("restart_len", len, 80);
    check("restart_seq", errs, 0);

    // abort in the very last clock: frame_done suppressed
    start(8, 10);
    wait_pos(9, 7, found);
    check("abort_last_found", int'(found), 1);
    bus.enable = 1'b0;
    #1;
    check("abort_last_gate",
          int'(bus.frame_done) + int'(bus.bit_done), 0);
    @(negedge CLK);
    check("abort_last_idle", outsum(), 0);
    bus.enable = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_last_not_done", int'(bus.edge_cnt), 1);

    // asynchronous reset mid-frame, enable held across release
    start(8, 10);
    repeat (37) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("rst_async", outsum() + int'(bus.cfg_err), 0);
    @(negedge CLK);
    check("rst_hold", outsum(), 0);
    RST = 1'b1;
    run_frame(8, 4, 10, -1, 0, len, nb, errs);
    check("rst_fresh_len", len, 80);
    check("rst_fresh_seq", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
